// File: rtl/orangecrab_reset_ctrl.sv
// Board-reset sequencer: qualifies masked requests, runs a cancellable grace countdown,
// then drives nreset_out low (latched or pulsed). Optional key gate: ORANGECRAB_RESET_KEY_EN.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// S_IDLE    | waiting for any masked request (and unlock when keyed)
// S_QUALIFY | request must stay high for HOLD_CYCLES; cancel/drop aborts
// S_ARMED   | grace countdown of DELAY_CYCLES; only cancel aborts
// S_ASSERT  | nreset_out low; held until rst_n (LATCH) or PULSE_CYCLES long
module orangecrab_reset_ctrl #(
   parameter int NUM_REQ      = 2,
   parameter int HOLD_CYCLES  = 1000,
   parameter int DELAY_CYCLES = 256,
   parameter int PULSE_CYCLES = 16,
   parameter bit LATCH        = 1'b1
`ifdef ORANGECRAB_RESET_KEY_EN
   ,
   parameter logic [7:0] KEY  = 8'hA5
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] req_mask,
   input  logic               cancel,
`ifdef ORANGECRAB_RESET_KEY_EN
   input  logic               key_valid,
   input  logic [7:0]         key_data,
`endif
   output logic               nreset_out,
   output logic               busy,
   output logic [NUM_REQ-1:0] src
);

   localparam int MAX_HD = (HOLD_CYCLES > DELAY_CYCLES) ? HOLD_CYCLES : DELAY_CYCLES;
   localparam int MAXV   = (MAX_HD > PULSE_CYCLES) ? MAX_HD : PULSE_CYCLES;
   localparam int CW     = $clog2(MAXV + 1);

   localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] DLY_TC  = CW'(DELAY_CYCLES);
   localparam logic [CW-1:0] PLS_TC  = CW'(PULSE_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_QUALIFY, S_ARMED, S_ASSERT} state_t;

   state_t              state, state_nxt;
   logic [NUM_REQ-1:0]  req_r;
   logic [NUM_REQ-1:0]  src_nxt;
   logic [CW-1:0]       hold_cnt, hold_nxt;
   logic [CW-1:0]       dly_cnt, dly_nxt;
   logic [CW-1:0]       pls_cnt, pls_nxt;
   logic                nreset_q, nreset_nxt;
   logic                any_r;
   logic                key_ok;
   logic                key_bad;

   assign any_r = |req_r;

`ifdef ORANGECRAB_RESET_KEY_EN
   logic unlocked;

   assign key_ok  = unlocked;
   assign key_bad = key_valid && (key_data != KEY);

   // Leaving the active sequence re-locks, so every sequence needs a fresh key.
   always_ff @(posedge clk) begin
      if (!rst_n)
         unlocked <= 1'b0;
      else if ((state_nxt == S_IDLE) && (state != S_IDLE))
         unlocked <= 1'b0;
      else if (key_valid)
         unlocked <= (key_data == KEY);
   end
`else
   assign key_ok  = 1'b1;
   assign key_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         req_r    <= '0;
         src      <= '0;
         hold_cnt <= '0;
         dly_cnt  <= '0;
         pls_cnt  <= '0;
         nreset_q <= 1'b1;
      end else begin
         state    <= state_nxt;
         req_r    <= req & req_mask;
         src      <= src_nxt;
         hold_cnt <= hold_nxt;
         dly_cnt  <= dly_nxt;
         pls_cnt  <= pls_nxt;
         nreset_q <= nreset_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      src_nxt    = src;
      hold_nxt   = hold_cnt;
      dly_nxt    = dly_cnt;
      pls_nxt    = pls_cnt;
      nreset_nxt = nreset_q;
      unique case (state)
         S_IDLE: begin
            nreset_nxt = 1'b1;
            if (any_r && key_ok) begin
               state_nxt = S_QUALIFY;
               hold_nxt  = CW'(1);
               src_nxt   = req_r;
            end
         end
         S_QUALIFY: begin
            if (!any_r || cancel || key_bad) begin
               state_nxt = S_IDLE;
               src_nxt   = '0;
            end else begin
               src_nxt = src | req_r;
               if (hold_cnt == HOLD_TC) begin
                  state_nxt = S_ARMED;
                  dly_nxt   = '0;
               end else begin
                  hold_nxt = hold_cnt + 1'b1;
               end
            end
         end
         S_ARMED: begin
            // cancel beats expiry on the same edge; src kept for readback
            if (cancel) begin
               state_nxt = S_IDLE;
            end else if (dly_cnt == DLY_TC) begin
               state_nxt  = S_ASSERT;
               nreset_nxt = 1'b0;
               pls_nxt    = CW'(1);
            end else begin
               dly_nxt = dly_cnt + 1'b1;
            end
         end
         S_ASSERT: begin
            nreset_nxt = 1'b0;
            if (!LATCH) begin
               if (pls_cnt == PLS_TC) begin
                  state_nxt  = S_IDLE;
                  nreset_nxt = 1'b1;
               end else begin
                  pls_nxt = pls_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign nreset_out = nreset_q;
   assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_orangecrab_reset_ctrl.sv
// Bench for orangecrab_reset_ctrl: a latched and a pulsed instance share random and directed
// stimulus and are compared every cycle against an elapsed-time reference model.
module tb_orangecrab_reset_ctrl;

   localparam int H0 = 4, D0 = 8, P0 = 3;
   localparam int H1 = 3, D1 = 0, P1 = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = '0;
   logic [1:0] req_mask = '0;
   logic       cancel = 1'b0;

   logic       nreset_l, busy_l, nreset_p, busy_p;
   logic [1:0] src_l, src_p;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   orangecrab_reset_ctrl #(
      .NUM_REQ(2), .HOLD_CYCLES(H0), .DELAY_CYCLES(D0), .PULSE_CYCLES(P0), .LATCH(1'b1)
   ) dut_l (
      .clk(clk), .rst_n(rst_n), .req(req), .req_mask(req_mask), .cancel(cancel),
`ifdef ORANGECRAB_RESET_KEY_EN
      .key_valid(1'b0), .key_data(8'h00),
`endif
      .nreset_out(nreset_l), .busy(busy_l), .src(src_l)
   );

   orangecrab_reset_ctrl #(
      .NUM_REQ(2), .HOLD_CYCLES(H1), .DELAY_CYCLES(D1), .PULSE_CYCLES(P1), .LATCH(1'b0)
   ) dut_p (
      .clk(clk), .rst_n(rst_n), .req(req), .req_mask(req_mask), .cancel(cancel),
`ifdef ORANGECRAB_RESET_KEY_EN
      .key_valid(1'b0), .key_data(8'h00),
`endif
      .nreset_out(nreset_p), .busy(busy_p), .src(src_p)
   );

   // Reference model: phase plus the edge at which the phase began.
   int         m_h[2], m_d[2], m_p[2];
   bit         m_l[2];
   int         ph[2];
   int         t0[2];
   bit         nrst_m[2];
   logic [1:0] src_m[2];
   logic [1:0] mreq_r = '0;
   int         edge_n = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            ph[i] = 0; nrst_m[i] = 1'b1; src_m[i] = '0;
         end else begin
            case (ph[i])
               0: if (mreq_r != 0) begin
                  ph[i] = 1; t0[i] = edge_n; src_m[i] = mreq_r;
               end
               1: if (mreq_r == 0 || cancel) begin
                  ph[i] = 0; src_m[i] = '0;
               end else begin
                  src_m[i] = src_m[i] | mreq_r;
                  if (edge_n - t0[i] == m_h[i]) begin ph[i] = 2; t0[i] = edge_n; end
               end
               2: if (cancel) ph[i] = 0;
                  else if (edge_n - t0[i] == m_d[i] + 1) begin
                     ph[i] = 3; t0[i] = edge_n; nrst_m[i] = 1'b0;
                  end
               3: if (!m_l[i] && edge_n - t0[i] == m_p[i]) begin
                  ph[i] = 0; nrst_m[i] = 1'b1;
               end
               default: ;
            endcase
         end
      end
      mreq_r = rst_n ? (req & req_mask) : 2'b00;
      edge_n++;
   endtask

   task automatic cyc(input logic rn, input logic [1:0] rq, input logic [1:0] mk, input logic cn);
      rst_n = rn; req = rq; req_mask = mk; cancel = cn;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("nrst_l", {31'b0, nreset_l}, {31'b0, nrst_m[0]});
      chk("busy_l", {31'b0, busy_l}, {31'b0, ph[0] != 0});
      chk("src_l", {30'b0, src_l}, {30'b0, src_m[0]});
      chk("nrst_p", {31'b0, nreset_p}, {31'b0, nrst_m[1]});
      chk("busy_p", {31'b0, busy_p}, {31'b0, ph[1] != 0});
      chk("src_p", {30'b0, src_p}, {30'b0, src_m[1]});
   endtask

   initial begin
      int fall_l, fall_p, rise_b, plen, l_rose, low_seen, busy_seen;
      int b10, b11;
      logic [1:0] s11;
      logic [1:0] r_req, r_mask;
      logic r_rn, r_cn;

      m_h[0] = H0; m_d[0] = D0; m_p[0] = P0; m_l[0] = 1'b1;
      m_h[1] = H1; m_d[1] = D1; m_p[1] = P1; m_l[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ph[i] = 0; t0[i] = 0; nrst_m[i] = 1'b1; src_m[i] = '0;
      end

      @(negedge clk);
      cyc(1'b0, 2'b00, 2'b01, 1'b0);
      cyc(1'b0, 2'b00, 2'b01, 1'b0);
      chk("rst_nrst", {31'b0, nreset_l}, 32'd1);
      chk("rst_busy", {31'b0, busy_l}, 32'd0);
      chk("rst_src", {30'b0, src_l}, 32'd0);

      // latency, latch hold, pulse width
      fall_l = -1; fall_p = -1; rise_b = -1; plen = -1; l_rose = 0;
      for (int j = 0; j < 115; j++) begin
         cyc(1'b1, 2'b01, 2'b01, 1'b0);
         if (busy_l && rise_b < 0) rise_b = j;
         if (!nreset_l && fall_l < 0) fall_l = j;
         if (fall_l >= 0 && nreset_l) l_rose = 1;
         if (!nreset_p && fall_p < 0) fall_p = j;
         if (fall_p >= 0 && nreset_p && plen < 0) plen = j - fall_p;
      end
      chk("lat_busy", rise_b, 32'd1);
      chk("lat_nrst_l", fall_l, 32'd14);
      chk("lat_nrst_p", fall_p, 32'd5);
      chk("pulse_len", plen, 32'd3);
      chk("latch_hold", l_rose, 32'd0);
      chk("latch_src", {30'b0, src_l}, 32'd1);

      cyc(1'b0, 2'b01, 2'b01, 1'b0);
      chk("rst_mid_nrst", {31'b0, nreset_l}, 32'd1);
      chk("rst_mid_busy", {31'b0, busy_l}, 32'd0);
      cyc(1'b0, 2'b00, 2'b01, 1'b0);

      // short request never qualifies
      low_seen = 0;
      for (int j = 0; j < 15; j++) begin
         cyc(1'b1, (j < 3) ? 2'b01 : 2'b00, 2'b01, 1'b0);
         if (!nreset_l || !nreset_p) low_seen = 1;
      end
      chk("short_nrst", low_seen, 32'd0);
      chk("short_src", {30'b0, src_l}, 32'd0);

      // masked source ignored
      busy_seen = 0;
      for (int j = 0; j < 50; j++) begin
         cyc(1'b1, 2'b10, 2'b01, 1'b0);
         if (busy_l || busy_p) busy_seen = 1;
      end
      chk("masked_busy", busy_seen, 32'd0);

      cyc(1'b0, 2'b00, 2'b01, 1'b0);
      // cancel while armed
      low_seen = 0; b10 = -1; b11 = -1; s11 = '0;
      for (int j = 0; j < 21; j++) begin
         cyc(1'b1, 2'b01, 2'b01, j == 11);
         if (!nreset_l) low_seen = 1;
         if (j == 10) b10 = busy_l;
         if (j == 11) begin b11 = busy_l; s11 = src_l; end
      end
      chk("cancel_armed", b10, 32'd1);
      chk("cancel_idle", b11, 32'd0);
      chk("cancel_src", {30'b0, s11}, 32'd1);
      chk("cancel_nrst", low_seen, 32'd0);

      // random traffic
      r_req = 2'b00; r_mask = 2'b11;
      for (int j = 0; j < 3000; j++) begin
         for (int b = 0; b < 2; b++) begin
            if ($urandom_range(0, 29) == 0) r_req[b] = ~r_req[b];
            if ($urandom_range(0, 99) == 0) r_mask[b] = ~r_mask[b];
         end
         r_cn = ($urandom_range(0, 49) == 0);
         r_rn = ($urandom_range(0, 299) != 0);
         cyc(r_rn, r_req, r_mask, r_cn);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
